// File: rtl/sdram_rv_bridge_pkg.sv
// Shared types and defaults for the CPU-to-SDRAM RV port bridge.
package configPackage;

    localparam int RD_WAIT_DEF = 4;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DATA,
        RESP
    } rvb_state_t;

endpackage

// File: rtl/sdram_rv_bridge.sv
// Splits 32-bit CPU accesses into 16-bit toggle-handshake SDRAM accesses
// and merges read halves back into one 32-bit response.
module sdram_rv_bridge
    import configPackage::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [20:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        sdram_busy,
    output logic [19:0] rv_addr,
    output logic [15:0] rv_din,
    output logic [1:0]  rv_ds,
    output logic        rv_we,
    output logic        rv_req,
    input  logic        rv_req_ack,
    input  logic [15:0] rv_dout
);

    localparam logic [7:0] LAST = 8'(RD_WAIT - 1);

    rvb_state_t  state;
    logic [20:2] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        rd_q;
    logic        hi_q;
    logic        more_q;
    logic [31:0] rd_buf;
    logic [7:0]  cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= SYNC;
            rv_req    <= 1'b0;
            rv_we     <= 1'b0;
            rv_ds     <= 2'b00;
            rv_addr   <= '0;
            rv_din    <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_q      <= 1'b0;
            hi_q      <= 1'b0;
            more_q    <= 1'b0;
            rd_buf    <= '0;
            cnt       <= '0;
        end else begin
            mem_ready <= 1'b0;
            unique case (state)
                SYNC: begin
                    // ack is arbitrary after reset; adopt it so nothing looks pending
                    if (!sdram_busy) begin
                        rv_req <= rv_req_ack;
                        state  <= IDLE;
                    end
                end
                IDLE: begin
                    // mem_ready high means the CPU still shows the finished request
                    if (mem_valid && !mem_ready) begin
                        addr_q  <= mem_addr[20:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        rd_q    <= (mem_wstrb == 4'b0000);
                        hi_q    <= (mem_wstrb != 4'b0000) &&
                                   (mem_wstrb[1:0] == 2'b00);
                        more_q  <= (mem_wstrb == 4'b0000) ||
                                   ((mem_wstrb[1:0] != 2'b00) &&
                                    (mem_wstrb[3:2] != 2'b00));
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rv_addr <= {addr_q, hi_q};
                    rv_din  <= hi_q ? wdata_q[31:16] : wdata_q[15:0];
                    rv_ds   <= rd_q ? 2'b11 :
                               (hi_q ? wstrb_q[3:2] : wstrb_q[1:0]);
                    rv_we   <= !rd_q;
                    rv_req  <= !rv_req;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (rv_req_ack == rv_req) begin
                        cnt <= '0;
                        if (rd_q) begin
                            state <= WAIT_DATA;
                        end else if (more_q) begin
                            hi_q   <= 1'b1;
                            more_q <= 1'b0;
                            state  <= ISSUE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (cnt == LAST) begin
                        if (hi_q) rd_buf[31:16] <= rv_dout;
                        else      rd_buf[15:0]  <= rv_dout;
                        if (more_q) begin
                            hi_q   <= 1'b1;
                            more_q <= 1'b0;
                            state  <= ISSUE;
                        end else begin
                            state <= RESP;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b1;
                    if (rd_q) mem_rdata <= rd_buf;
                    state <= IDLE;
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_rv_bridge.sv
// Bench for sdram_rv_bridge: controller model plus byte-level memory reference.
module tb_sdram_rv_bridge;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] din;
        logic [1:0]  ds;
        logic        we;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [20:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        sdram_busy;
    logic [19:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_req_ack;
    logic [15:0] rv_dout;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int stab_err = 0;
    int acks = 0;
    int fixed_delay = 0;

    req_t log_q[$];
    logic [15:0] hmem [int];
    logic [7:0]  bmem [int];

    sdram_rv_bridge #(.RD_WAIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .sdram_busy(sdram_busy),
        .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds),
        .rv_we(rv_we), .rv_req(rv_req), .rv_req_ack(rv_req_ack),
        .rv_dout(rv_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_ready === 1'b1) ready_cnt++;

    function automatic logic [7:0] init_byte(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [15:0] hw_rd(input int a);
        if (hmem.exists(a)) return hmem[a];
        return {init_byte(2 * a + 1), init_byte(2 * a)};
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        if (bmem.exists(a)) return bmem[a];
        return init_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int hw, input logic [15:0] v);
        hmem[hw] = v;
        bmem[2 * hw] = v[7:0];
        bmem[2 * hw + 1] = v[15:8];
    endtask

    // Controller model: serves one toggle request after a delay, read data valid 2 clk after ack
    initial begin
        req_t cur;
        int acnt;
        int dcnt;
        logic [15:0] dval;
        logic [15:0] v;
        bit pend;
        rv_req_ack = 1'b1;
        rv_dout = 16'h0;
        pend = 0;
        dcnt = 0;
        acnt = 0;
        dval = 0;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) rv_dout = dval;
            end
            if (resetn !== 1'b1 || sdram_busy !== 1'b0) begin
                pend = 0;
            end else if (pend) begin
                if (rv_addr !== cur.addr || rv_din !== cur.din ||
                    rv_ds !== cur.ds || rv_we !== cur.we) stab_err++;
                acnt--;
                if (acnt == 0) begin
                    if (cur.we) begin
                        v = hw_rd(int'(cur.addr));
                        if (cur.ds[0]) v[7:0] = cur.din[7:0];
                        if (cur.ds[1]) v[15:8] = cur.din[15:8];
                        hmem[int'(cur.addr)] = v;
                    end else begin
                        dval = hw_rd(int'(cur.addr));
                        rv_dout = 16'($urandom);
                        dcnt = 2;
                    end
                    rv_req_ack = rv_req;
                    pend = 0;
                    acks++;
                end
            end else if (rv_req !== rv_req_ack) begin
                pend = 1;
                cur = '{rv_addr, rv_din, rv_ds, rv_we};
                log_q.push_back(cur);
                acnt = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(2, 7));
            end
        end
    end

    task automatic access(input logic [20:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int drop);
        req_t exp_q[$];
        int base;
        int rc0;
        int cyc;
        int al;
        bit got;
        logic [31:0] exp_rd;
        base = log_q.size();
        rc0 = ready_cnt;
        al = int'({a[20:2], 2'b00});
        for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = ref_byte(al + i);
        if (ws == 4'b0000) begin
            exp_q.push_back('{20'(al / 2), wd[15:0], 2'b11, 1'b0});
            exp_q.push_back('{20'(al / 2 + 1), wd[31:16], 2'b11, 1'b0});
        end else begin
            if (ws[1:0] != 2'b00)
                exp_q.push_back('{20'(al / 2), wd[15:0], ws[1:0], 1'b1});
            if (ws[3:2] != 2'b00)
                exp_q.push_back('{20'(al / 2 + 1), wd[31:16], ws[3:2], 1'b1});
            for (int i = 0; i < 4; i++)
                if (ws[i]) bmem[al + i] = wd[8*i +: 8];
        end
        @(negedge clk);
        mem_addr = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_valid = 1'b1;
        got = 0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (drop != 0 && cyc == drop) mem_valid = 1'b0;
            if (mem_ready === 1'b1) got = 1;
        end
        mem_valid = 1'b0;
        chk("ready_seen", 32'(got), 32'd1);
        chk("req_count", 32'(log_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
            chk("rv_addr", 32'(log_q[base+i].addr), 32'(exp_q[i].addr));
            chk("rv_ds", 32'(log_q[base+i].ds), 32'(exp_q[i].ds));
            chk("rv_we", 32'(log_q[base+i].we), 32'(exp_q[i].we));
            if (exp_q[i].we)
                chk("rv_din", 32'(log_q[base+i].din), 32'(exp_q[i].din));
        end
        if (ws == 4'b0000) chk("mem_rdata", mem_rdata, exp_rd);
        repeat (3) @(negedge clk);
        chk("ready_pulses", 32'(ready_cnt - rc0), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int a0;
        int rc0;
        int cyc;
        logic [3:0] ws;
        logic [20:0] a;
        resetn = 1'b0;
        sdram_busy = 1'b1;
        mem_valid = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("rst_rv_req", 32'(rv_req), 32'd0);
        chk("rst_rv_we", 32'(rv_we), 32'd0);
        chk("rst_rv_ds", 32'(rv_ds), 32'd0);
        chk("rst_rv_addr", 32'(rv_addr), 32'd0);
        chk("rst_rv_din", 32'(rv_din), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        resetn = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (rv_req !== 1'b0) bad++;
        end
        chk("busy_no_toggle", 32'(bad), 32'd0);
        sdram_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("sync_rv_req", 32'(rv_req), 32'd1);
        chk("sync_no_pending", 32'(rv_req ^ rv_req_ack), 32'd0);
        chk("sync_no_log", 32'(log_q.size()), 32'd0);

        preload(32'h82, 16'hBEEF);
        preload(32'h83, 16'hCAFE);
        access(21'h00104, 32'h0, 4'b0000, 0);
        chk("read_cafebeef", mem_rdata, 32'hCAFEBEEF);

        access(21'h00010, 32'h12345678, 4'b1100, 0);
        access(21'h00020, 32'hAABBCCDD, 4'b0101, 0);
        access(21'h00020, 32'h0, 4'b0000, 0);
        access(21'h00010, 32'h0, 4'b0000, 0);

        fixed_delay = 7;
        access(21'h00104, 32'h0, 4'b0000, 2);
        access(21'h00200, 32'h55667788, 4'b0011, 2);
        chk("fields_stable", 32'(stab_err), 32'd0);
        fixed_delay = 0;

        for (int n = 0; n < 40; n++) begin
            a = 21'h01000 + 21'($urandom_range(0, 15) * 4);
            ws = ($urandom_range(0, 1) == 0) ? 4'b0000
                                            : 4'($urandom_range(1, 15));
            access(a, $urandom, ws, 0);
        end
        chk("rand_fields_stable", 32'(stab_err), 32'd0);

        fixed_delay = 3;
        rc0 = ready_cnt;
        a0 = acks;
        @(negedge clk);
        mem_addr = 21'h00104;
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        cyc = 0;
        while (acks == a0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_half_ack", 32'(acks != a0), 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        sdram_busy = 1'b1;
        #1;
        chk("arst_mem_ready", 32'(mem_ready), 32'd0);
        chk("arst_rv_req", 32'(rv_req), 32'd0);
        chk("arst_rv_ds", 32'(rv_ds), 32'd0);
        chk("arst_rv_we", 32'(rv_we), 32'd0);
        chk("arst_rv_addr", 32'(rv_addr), 32'd0);
        chk("arst_rv_din", 32'(rv_din), 32'd0);
        chk("arst_mem_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        sdram_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("resync_no_pending", 32'(rv_req ^ rv_req_ack), 32'd0);
        chk("arst_no_ready", 32'(ready_cnt - rc0), 32'd0);
        fixed_delay = 0;
        access(21'h00104, 32'h0, 4'b0000, 0);
        access(21'h00020, 32'h0, 4'b0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_rv_bridge.md
# sdram_rv_bridge

Adapter between the RISC-V softcore's native 32-bit memory bus (valid/ready, byte strobes) and the 16-bit toggle-handshake RV port of the NES SDRAM controller. Each 32-bit access is split into one or two 16-bit SDRAM accesses, and the halves are merged back into one 32-bit read response. The bridge owns the `rv_req` toggle and sequences requests so that no more than one is ever outstanding.

## Interface
- `RD_WAIT`, default 4: clk cycles after the ack is observed before `rv_dout` is sampled (≥3 required by controller slot timing).
- `clk`  in  1  SDRAM clock, same clock as the controller.
- `resetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `mem_valid`  in  1  CPU request; held until `mem_ready`.
- `mem_addr`  in  21  byte address in the 2MB RV window; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid with `mem_ready`, held until the next read completes.
- `sdram_busy`  in  1  controller init in progress (`busy` of controller).
- `rv_addr`  out  20  halfword address [20:1].
- `rv_din`  out  16  write halfword.
- `rv_ds`  out  2  halfword byte selects, active high.
- `rv_we`  out  1  write flag.
- `rv_req`  out  1  request toggle.
- `rv_req_ack`  in  1  controller ack toggle (not reset by the controller).
- `rv_dout`  in  16  read halfword.

## Operation
- Reset values: `rv_req`=0, `rv_we`=0, `rv_ds`=0, `rv_addr`=0, `rv_din`=0, `mem_ready`=0, `mem_rdata`=0, state=SYNC.
- A request is pending while `rv_req != rv_req_ack`. Issuing a request means driving `rv_addr`/`rv_din`/`rv_ds`/`rv_we` and toggling `rv_req` on the same edge. These fields stay stable until the ack matches.
- SYNC: wait while `sdram_busy`=1. Then set `rv_req <= rv_req_ack` and go to IDLE. This prevents a spurious request, because the ack has arbitrary value after reset.
- IDLE: on `mem_valid`, latch addr/wdata/wstrb.
  - Read: do LO, then HI.
  - Write: do LO only if `wstrb[1:0]!=0`, and HI only if `wstrb[3:2]!=0`.
- LO half: `rv_addr={addr[20:2],1'b0}`, `rv_din=wdata[15:0]`, `rv_ds` = `wstrb[1:0]` on write, 2'b11 on read.
- HI half: `rv_addr={addr[20:2],1'b1}`, `rv_din=wdata[31:16]`, `rv_ds` = `wstrb[3:2]` on write, 2'b11 on read.
- States: SYNC, IDLE, ISSUE, WAIT_ACK, WAIT_DATA, RESP.
  - ISSUE → WAIT_ACK.
  - WAIT_ACK → WAIT_DATA (read) or next half / RESP (write) on the first cycle `rv_req_ack==rv_req`.
  - WAIT_DATA counts `RD_WAIT` cycles, captures `rv_dout` into the lo or hi half of a 32-bit register, then goes to the next half or RESP.
  - RESP pulses `mem_ready` for 1 cycle, updates `mem_rdata` (reads only), then → IDLE.
- A write that is not word-aligned is not possible, since bits [1:0] are ignored.

## Timing
- `mem_valid` is sampled in IDLE. ISSUE is the next cycle; `rv_req` toggles on the edge leaving ISSUE.
- The controller acks in its next RV slot (cycle 4 of its 6-clk round), so each half takes 2–7 clk to ack.
- Read latency per half is ack + `RD_WAIT`.
- Full read: roughly 12–22 clk from `mem_valid` to `mem_ready`. Single-half write: roughly 4–9 clk.
- `mem_ready` asserts at most once per accepted request. The bridge accepts a new request on the cycle after `mem_ready`, and never in the same cycle.
- `mem_valid` dropping mid-transaction has no effect: the transaction completes and `mem_ready` still pulses.
- `sdram_busy` rising outside SYNC is ignored, because it is only asserted during init.
- Async reset mid-transaction: outputs go to their reset values immediately and the state returns to SYNC. Re-sync absorbs any half-issued request; its ack may land and is ignored.

## Structure
- Put the state enum `rvb_state_t` and the `RD_WAIT` default in `configPackage`.
- Single module; no sub-module. The toggle handshake is a few flops and is not worth factoring out.

## Test plan
- Reset with `rv_req_ack`=1 and `sdram_busy`=1 for 50 clk → no toggle of `rv_req` while busy. After busy falls, `rv_req` becomes 1 and no request is pending.
- Read `mem_addr`=0x00104 against a controller model holding 0xBEEF at halfword 0x82 and 0xCAFE at halfword 0x83 → exactly two requests, both with `rv_ds`=2'b11, then `mem_rdata`=0xCAFEBEEF with a single `mem_ready` pulse.
- Write `wstrb`=4'b1100, `wdata`=0x12345678 at 0x00010 → one request only: `rv_addr`=0x00009, `rv_din`=0x1234, `rv_ds`=2'b11, `rv_we`=1.
- Write `wstrb`=4'b0101, `wdata`=0xAABBCCDD → two requests: LO with `rv_ds`=2'b01 and `rv_din`=0xCCDD, then HI with `rv_ds`=2'b01 and `rv_din`=0xAABB.
- Controller model delays the ack by 7 clk and `mem_valid` drops after 2 clk → `rv_*` fields stay stable until the ack, and `mem_ready` still pulses once.
- Assert reset during WAIT_DATA → `mem_ready`=0 and outputs return to reset values. After resync, a subsequent read returns correct data.
